// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N-channel round-robin mux.
// Imported by mux_nxw_rr and rr_pick.
package mux_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  function automatic int clog2_min1(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set req bit at or after ptr, wrapping.
// Rotates a doubled request vector, then does a fixed priority scan.
module rr_pick
  import mux_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int SEL_W    = clog2_min1(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  output logic                any,
  output logic [SEL_W-1:0]    idx
);

  localparam int SW1 = SEL_W + 1;

  logic [CHANNELS-1:0] rot;
  logic [SW1-1:0]      pos;

  // rot[j] is req[(ptr + j) mod CHANNELS]; ptr is always < CHANNELS
  assign rot = CHANNELS'({req, req} >> ptr);

  always_comb begin
    any = 1'b0;
    idx = '0;
    pos = '0;
    for (int j = CHANNELS - 1; j >= 0; j--) begin
      if (rot[j]) begin
        any = 1'b1;
        pos = {1'b0, ptr} + SW1'(j);
        if (pos >= SW1'(CHANNELS)) begin
          pos = pos - SW1'(CHANNELS);
        end
        idx = pos[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mux_nxw_rr.sv
// CHANNELS x WIDTH mux, direct or round-robin select,
// feeding a one-entry registered valid/ready output stage.
module mux_nxw_rr
  import mux_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = clog2_min1(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          select,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int NP  = 1 << SEL_W;
  localparam int SW1 = SEL_W + 1;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             rr_any;
  logic [SEL_W-1:0] rr_idx;
  logic [NP-1:0]    vpad;
  logic             sel_ok;
  logic             grant;
  logic [SEL_W-1:0] gidx;
  logic [WIDTH-1:0] gword;
  logic [SEL_W-1:0] ptr_nxt;
  logic             load;
  logic             xfer;

  rr_pick #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_pick (
    .req (in_valid),
    .ptr (ptr_q),
    .any (rr_any),
    .idx (rr_idx)
  );

  // Padded so an out-of-range select reads a zero, never an X
  assign vpad   = NP'(in_valid);
  assign sel_ok = {1'b0, select} < SW1'(CHANNELS);

  always_comb begin
    grant = 1'b0;
    gidx  = '0;
    case (mode)
      MODE_RR: begin
        grant = rr_any;
        gidx  = rr_idx;
      end
      MODE_DIRECT: begin
        grant = sel_ok && vpad[select];
        gidx  = select;
      end
      default: ;
    endcase
  end

  always_comb begin
    gword = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (SEL_W'(i) == gidx) begin
        gword = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign load = !valid_q || out_ready;
  assign xfer = load && grant && !reset;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      in_ready[i] = xfer && (SEL_W'(i) == gidx);
    end
  end

  // Explicit wrap so non-power-of-two CHANNELS works
  assign ptr_nxt = (gidx == SEL_W'(CHANNELS - 1))
                 ? '0 : gidx + SEL_W'(1);

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (load) begin
      valid_d = grant;
      if (grant) begin
        data_d = gword;
        sel_d  = gidx;
        if (mode == MODE_RR) begin
          ptr_d = ptr_nxt;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_sel   = sel_q;

endmodule

// File: tb/tb_mux_nxw_rr.sv
// Bench for mux_nxw_rr: directed vector table, a 6-channel
// out-of-range select check, then random traffic vs a model.
module tb_mux_nxw_rr;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic [7:0]  in_valid;
  logic [7:0]  in_ready;
  logic        mode;
  logic [2:0]  select;
  logic [3:0]  out_data;
  logic [2:0]  out_sel;
  logic        out_valid;
  logic        out_ready;

  logic [23:0] d6_in_data;
  logic [5:0]  d6_in_valid;
  logic [5:0]  d6_in_ready;
  logic        d6_mode;
  logic [2:0]  d6_select;
  logic [3:0]  d6_out_data;
  logic [2:0]  d6_out_sel;
  logic        d6_out_valid;
  logic        d6_out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mux_nxw_rr #(.WIDTH(4), .CHANNELS(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .select    (select),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  mux_nxw_rr #(.WIDTH(4), .CHANNELS(6)) dut6 (
    .clk       (clk),
    .reset     (reset),
    .in_data   (d6_in_data),
    .in_valid  (d6_in_valid),
    .in_ready  (d6_in_ready),
    .mode      (d6_mode),
    .select    (d6_select),
    .out_data  (d6_out_data),
    .out_sel   (d6_out_sel),
    .out_valid (d6_out_valid),
    .out_ready (d6_out_ready)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model of the 8-channel instance
  bit         m_v   = 1'b0;
  logic [3:0] m_d   = 4'h0;
  int         m_s   = 0;
  int         m_ptr = 0;

  function automatic void model_grant(output bit g,
                                      output int gi);
    g  = 1'b0;
    gi = 0;
    if (mode == 1'b0) begin
      gi = int'(select);
      g  = (gi < 8) && in_valid[gi];
    end else begin
      for (int k = 0; k < 8; k++) begin
        int c;
        c = (m_ptr + k) % 8;
        if (!g && in_valid[c]) begin
          g  = 1'b1;
          gi = c;
        end
      end
    end
  endfunction

  task automatic check_model(input string tag);
    bit         g;
    int         gi;
    logic [7:0] eir;
    logic [2:0] es;
    model_grant(g, gi);
    eir = ((!m_v || out_ready) && g && !reset)
        ? 8'(1 << gi) : 8'h00;
    es  = 3'(m_s);
    chk({tag, "_ov"}, 32'(out_valid), 32'(m_v));
    chk({tag, "_od"}, 32'(out_data), 32'(m_d));
    chk({tag, "_os"}, 32'(out_sel), 32'(es));
    chk({tag, "_ir"}, 32'(in_ready), 32'(eir));
  endtask

  task automatic model_step();
    bit g;
    int gi;
    model_grant(g, gi);
    if (reset) begin
      m_v   = 1'b0;
      m_d   = 4'h0;
      m_s   = 0;
      m_ptr = 0;
    end else if (!m_v || out_ready) begin
      m_v = g;
      if (g) begin
        m_d = in_data[gi*4 +: 4];
        m_s = gi;
        if (mode) m_ptr = (gi + 1) % 8;
      end
    end
  endtask

  typedef struct {
    logic       rst;
    logic       md;
    logic [2:0] sel;
    logic [7:0] vld;
    logic       ordy;
    logic       e_ov;
    logic [3:0] e_od;
    logic [2:0] e_os;
    logic [7:0] e_ir;
  } vec_t;

  localparam int NV = 33;
  vec_t tbl [NV];

  initial begin
    // Outputs expected at each row reflect the previous edge
    tbl[0]  = '{1, 0, 0, 8'hFF, 1, 0, 0, 0, 8'h00};
    tbl[1]  = '{0, 0, 0, 8'hFF, 1, 0, 0, 0, 8'h01};
    tbl[2]  = '{0, 0, 1, 8'hFF, 1, 1, 0, 0, 8'h02};
    tbl[3]  = '{0, 0, 2, 8'hFF, 1, 1, 1, 1, 8'h04};
    tbl[4]  = '{0, 0, 3, 8'hFF, 1, 1, 2, 2, 8'h08};
    tbl[5]  = '{0, 0, 4, 8'hFF, 1, 1, 3, 3, 8'h10};
    tbl[6]  = '{0, 0, 5, 8'hFF, 1, 1, 4, 4, 8'h20};
    tbl[7]  = '{0, 0, 6, 8'hFF, 1, 1, 5, 5, 8'h40};
    tbl[8]  = '{0, 0, 7, 8'hFF, 1, 1, 6, 6, 8'h80};
    tbl[9]  = '{0, 1, 0, 8'hA5, 1, 1, 7, 7, 8'h01};
    tbl[10] = '{0, 1, 0, 8'hA5, 1, 1, 0, 0, 8'h04};
    tbl[11] = '{0, 1, 0, 8'hA5, 1, 1, 2, 2, 8'h20};
    tbl[12] = '{0, 1, 0, 8'hA5, 1, 1, 5, 5, 8'h80};
    tbl[13] = '{0, 1, 0, 8'hA5, 1, 1, 7, 7, 8'h01};
    tbl[14] = '{0, 1, 0, 8'hA5, 1, 1, 0, 0, 8'h04};
    tbl[15] = '{0, 1, 0, 8'hA5, 1, 1, 2, 2, 8'h20};
    tbl[16] = '{0, 1, 0, 8'hA5, 1, 1, 5, 5, 8'h80};
    tbl[17] = '{0, 1, 0, 8'hFF, 1, 1, 7, 7, 8'h01};
    tbl[18] = '{0, 1, 0, 8'hFF, 0, 1, 0, 0, 8'h00};
    tbl[19] = '{0, 1, 0, 8'hFF, 0, 1, 0, 0, 8'h00};
    tbl[20] = '{0, 1, 0, 8'hFF, 0, 1, 0, 0, 8'h00};
    tbl[21] = '{0, 1, 0, 8'hFF, 1, 1, 0, 0, 8'h02};
    tbl[22] = '{0, 1, 0, 8'hFF, 1, 1, 1, 1, 8'h04};
    tbl[23] = '{0, 0, 3, 8'hF7, 1, 1, 2, 2, 8'h00};
    tbl[24] = '{0, 0, 3, 8'hF7, 1, 0, 2, 2, 8'h00};
    tbl[25] = '{0, 1, 3, 8'h10, 1, 0, 2, 2, 8'h10};
    tbl[26] = '{0, 0, 1, 8'hFF, 1, 1, 4, 4, 8'h02};
    tbl[27] = '{0, 1, 1, 8'hFF, 1, 1, 1, 1, 8'h20};
    tbl[28] = '{0, 1, 1, 8'hFF, 1, 1, 5, 5, 8'h40};
    tbl[29] = '{0, 1, 1, 8'hFF, 0, 1, 6, 6, 8'h00};
    tbl[30] = '{1, 1, 1, 8'hFF, 0, 1, 6, 6, 8'h00};
    tbl[31] = '{0, 1, 1, 8'h60, 0, 0, 0, 0, 8'h20};
    tbl[32] = '{0, 1, 1, 8'h60, 1, 1, 5, 5, 8'h40};

    reset        = 1'b1;
    mode         = 1'b0;
    select       = 3'd0;
    in_valid     = 8'hFF;
    out_ready    = 1'b1;
    in_data      = 32'h7654_3210;
    d6_in_data   = 24'h54_3210;
    d6_in_valid  = 6'h00;
    d6_mode      = 1'b0;
    d6_select    = 3'd0;
    d6_out_ready = 1'b1;
    repeat (2) @(negedge clk);

    for (int r = 0; r < NV; r++) begin
      string t;
      reset     = tbl[r].rst;
      mode      = tbl[r].md;
      select    = tbl[r].sel;
      in_valid  = tbl[r].vld;
      out_ready = tbl[r].ordy;
      #1;
      t = $sformatf("vec%0d", r);
      chk({t, "_ov"}, 32'(out_valid), 32'(tbl[r].e_ov));
      chk({t, "_od"}, 32'(out_data), 32'(tbl[r].e_od));
      chk({t, "_os"}, 32'(out_sel), 32'(tbl[r].e_os));
      chk({t, "_ir"}, 32'(in_ready), 32'(tbl[r].e_ir));
      model_step();
      @(negedge clk);
    end

    // Six-channel instance: select 7 is out of range
    in_valid    = 8'h00;
    d6_in_valid = 6'h3F;
    d6_select   = 3'd5;
    #1;
    chk("c6_ir_sel5", 32'(d6_in_ready), 32'h20);
    model_step();
    @(negedge clk);
    d6_select = 3'd7;
    #1;
    chk("c6_ov_sel5", 32'(d6_out_valid), 32'd1);
    chk("c6_os_sel5", 32'(d6_out_sel), 32'd5);
    chk("c6_ir_sel7", 32'(d6_in_ready), 32'h00);
    model_step();
    @(negedge clk);
    #1;
    chk("c6_ov_sel7", 32'(d6_out_valid), 32'd0);
    chk("c6_os_hold", 32'(d6_out_sel), 32'd5);
    chk("c6_od_hold", 32'(d6_out_data), 32'd5);
    model_step();
    @(negedge clk);

    for (int n = 0; n < 600; n++) begin
      reset     = ($urandom_range(0, 39) == 0);
      mode      = 1'($urandom_range(0, 1));
      select    = 3'($urandom_range(0, 7));
      in_valid  = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      #1;
      check_model($sformatf("rnd%0d", n));
      model_step();
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
